// File: rtl/id_stage_pkg.sv
// id_stage_pkg
//   Shared types and decode helpers for the queued RV32I decode stage.
//   id_stage_in_t  : IF -> ID queue entry {inst, pc, pc4}
//   id_stage_out_t : ID -> EX pipeline register contents
//   gen_imm_f      : immediate generation for all RV32I formats
//   decode_ctrl_f  : control fields plus illegal flag for one instruction
//   uses_rs1_f / uses_rs2_f : which source registers an opcode actually reads
package id_stage_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int QDEPTH_DEF = 2;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
  } id_stage_in_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [6:0]  opcode;     // raw field, so unrecognised opcodes stay visible
    logic        rf_en;      // instruction writes rd
    logic        dm_en;      // data memory access
    logic        dm_we;      // data memory write
  } id_stage_out_t;

  typedef struct packed {
    logic rf_en;
    logic dm_en;
    logic dm_we;
    logic illegal;
  } ctrl_t;

  function automatic logic [31:0] gen_imm_f(input logic [31:0] inst);
    logic [31:0] imm;
    imm = '0;
    case (inst[6:0])
      OPC_OPIMM, OPC_LOAD, OPC_JALR:
        imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

  function automatic ctrl_t decode_ctrl_f(input logic [31:0] inst);
    ctrl_t c;
    c = '0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OPIMM, OPC_OP:
        c.rf_en = 1'b1;
      OPC_BRANCH:
        c.rf_en = 1'b0;
      OPC_LOAD: begin
        c.rf_en = 1'b1;
        c.dm_en = 1'b1;
      end
      OPC_STORE: begin
        c.dm_en = 1'b1;
        c.dm_we = 1'b1;
      end
      default:
        c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic uses_rs1_f(input logic [6:0] opc);
    case (opc)
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2_f(input logic [6:0] opc);
    case (opc)
      OPC_BRANCH, OPC_STORE, OPC_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_queued_queue.sv
// id_inst_queue
//   Circular FIFO of id_stage_in_t between IF and ID.
//   clk, rst      : clock, async active-high reset
//   flush_i       : empties the queue at the next edge; push/pop that cycle are dropped
//   push_i/data_i : write request and entry (ignored when full)
//   pop_i         : consume the head (ignored when empty)
//   head_o        : current head entry, head_valid_o when the queue is non-empty
//   ready_o       : queue has a free slot
module id_inst_queue
  import id_stage_pkg::*;
#(
  parameter int QDEPTH = QDEPTH_DEF
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  id_stage_in_t data_i,
  input  logic         pop_i,
  output id_stage_in_t head_o,
  output logic         head_valid_o,
  output logic         ready_o
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW    = $clog2(QDEPTH + 1);

  if ((QDEPTH < 2) || ((QDEPTH & (QDEPTH - 1)) != 0)) begin : g_bad_depth
    $error("id_inst_queue: QDEPTH must be a power of two and at least 2");
  end

  id_stage_in_t     mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CW-1:0]    count;
  logic             push_eff;
  logic             pop_eff;

  assign ready_o      = (count < CW'(QDEPTH));
  assign head_valid_o = (count != '0);
  assign head_o       = mem[rd_ptr];

  assign push_eff = push_i & ready_o & ~flush_i;
  assign pop_eff  = pop_i & head_valid_o & ~flush_i;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage has no reset; count gates visibility, so stale slots are never read as valid.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_eff)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/id_stage_queued.sv
// id_stage_queued
//   RV32I decode stage fed by a small instruction queue.
//   IF side : in_valid_i / in_ready_o / in_i
//   RF side : rs1_addr_o, rs2_addr_o out; rs1_data_i, rs2_data_i in (combinational read)
//   WB side : wb_en_i, wb_rd_i, wb_data_i (bypassed into operands)
//   EX side : ex_load_i, ex_rd_i (load-use interlock); out_valid_o / out_ready_i / id_out_o
//   Status  : illegal_o (registered with id_out_o), stall_cnt_o (saturating)
//   flush_i : discards the queue and the output register at the next edge
module id_stage_queued
  import id_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int QDEPTH = QDEPTH_DEF,
  parameter int CNT_W  = 32
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  id_stage_in_t     in_i,
  output logic [4:0]       rs1_addr_o,
  output logic [4:0]       rs2_addr_o,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic             wb_en_i,
  input  logic [4:0]       wb_rd_i,
  input  logic [XLEN-1:0]  wb_data_i,
  input  logic             ex_load_i,
  input  logic [4:0]       ex_rd_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output id_stage_out_t    id_out_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("id_stage_queued: only XLEN=32 is supported");
  end

  id_stage_in_t  head;
  logic          head_valid;
  logic [31:0]   inst;
  logic [6:0]    opc;
  ctrl_t         ctrl;
  logic          hazard;
  logic          out_free;
  logic          load;
  id_stage_out_t dec;

  id_inst_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .push_i       (in_valid_i),
    .data_i       (in_i),
    .pop_i        (load),
    .head_o       (head),
    .head_valid_o (head_valid),
    .ready_o      (in_ready_o)
  );

  assign inst       = head.inst;
  assign opc        = inst[6:0];
  assign rs1_addr_o = inst[19:15];
  assign rs2_addr_o = inst[24:20];
  assign ctrl       = decode_ctrl_f(inst);

  // x0 is hard zero; a same-cycle WB write to the source wins over the stale RF read.
  function automatic logic [XLEN-1:0] operand_f(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            we,
    input logic [4:0]      wrd,
    input logic [XLEN-1:0] wdata
  );
    if (rs == 5'd0)                return '0;
    else if (we && (wrd == rs))    return wdata;
    else                           return rf_data;
  endfunction

  // Only stall on sources the opcode really reads, so unrecognised opcodes never stall.
  assign hazard = ex_load_i && (ex_rd_i != 5'd0) &&
                  ((uses_rs1_f(opc) && (ex_rd_i == rs1_addr_o)) ||
                   (uses_rs2_f(opc) && (ex_rd_i == rs2_addr_o)));

  assign out_free = ~out_valid_o | out_ready_i;
  assign load     = head_valid & ~hazard & out_free;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    dec           = '0;
    dec.pc        = head.pc;
    dec.pc4       = head.pc4;
    dec.imm       = gen_imm_f(inst);
    dec.opr_a     = operand_f(rs1_addr_o, rs1_data_i, wb_en_i, wb_rd_i, wb_data_i);
    dec.opr_b     = operand_f(rs2_addr_o, rs2_data_i, wb_en_i, wb_rd_i, wb_data_i);
    dec.rd        = inst[11:7];
    dec.rs1       = rs1_addr_o;
    dec.rs2       = rs2_addr_o;
    dec.funct3    = inst[14:12];
    dec.funct7_b5 = inst[30];
    dec.opcode    = opc;
    dec.rf_en     = ctrl.rf_en;
    dec.dm_en     = ctrl.dm_en;
    dec.dm_we     = ctrl.dm_we;
  end

  // Output register: payload only changes on a load, so it holds under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      id_out_o    <= '0;
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
      illegal_o   <= 1'b0;
    end else if (load) begin
      out_valid_o <= 1'b1;
      id_out_o    <= dec;
      illegal_o   <= ctrl.illegal;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
      illegal_o   <= 1'b0;
    end
  end

  // Counts cycles lost to the interlock only; flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (head_valid && hazard && out_free && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_stage_queued.sv
module tb_id_stage_queued;
  import id_stage_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  id_stage_in_t  in_i;
  logic [4:0]    rs1_addr_o, rs2_addr_o;
  logic [31:0]   rs1_data_i, rs2_data_i;
  logic          wb_en_i;
  logic [4:0]    wb_rd_i;
  logic [31:0]   wb_data_i;
  logic          ex_load_i;
  logic [4:0]    ex_rd_i;
  logic          out_valid_o;
  logic          out_ready_i;
  id_stage_out_t id_out_o;
  logic          illegal_o;
  logic [31:0]   stall_cnt_o;

  id_stage_queued #(.XLEN(32), .QDEPTH(2), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_i        (in_i),
    .rs1_addr_o  (rs1_addr_o),
    .rs2_addr_o  (rs2_addr_o),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .wb_en_i     (wb_en_i),
    .wb_rd_i     (wb_rd_i),
    .wb_data_i   (wb_data_i),
    .ex_load_i   (ex_load_i),
    .ex_rd_i     (ex_rd_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .id_out_o    (id_out_o),
    .illegal_o   (illegal_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  // Register file model: x0 returns garbage so the zero rule is visible, x2 holds 1.
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    if (a == 5'd0)      return 32'hBAD0_0000;
    else if (a == 5'd2) return 32'h0000_0001;
    else                return 32'h1000_0000 | {27'd0, a};
  endfunction

  assign rs1_data_i = rf_val(rs1_addr_o);
  assign rs2_data_i = rf_val(rs2_addr_o);

  typedef struct packed {
    id_stage_out_t out;
    logic          illegal;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  sb_entry_t mon_e;
  int        n_checks = 0;
  int        n_pass   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic id_stage_out_t mk(
    input logic [31:0] pc, input logic [31:0] imm,
    input logic [31:0] a, input logic [31:0] b,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [2:0] f3, input logic f7, input logic [6:0] opc,
    input logic rf, input logic dm, input logic we);
    id_stage_out_t o;
    o = '0;
    o.pc = pc; o.pc4 = pc + 32'd4; o.imm = imm; o.opr_a = a; o.opr_b = b;
    o.rd = rd; o.rs1 = rs1; o.rs2 = rs2; o.funct3 = f3; o.funct7_b5 = f7;
    o.opcode = opc; o.rf_en = rf; o.dm_en = dm; o.dm_we = we;
    return o;
  endfunction

  task automatic expect_out(input id_stage_out_t o, input logic ill);
    sb_entry_t e;
    e.out = o;
    e.illegal = ill;
    sb_q.push_back(e);
  endtask

  // Monitor: a presented-and-accepted output is consumed at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_out: got id_out=%0h illegal=%b expected no output", id_out_o, illegal_o);
      end else begin
        mon_e = sb_q.pop_front();
        if ((id_out_o !== mon_e.out) || (illegal_o !== mon_e.illegal))
          $display("FAIL out_pc%0h: got id_out=%0h illegal=%b expected id_out=%0h illegal=%b",
                   mon_e.out.pc, id_out_o, illegal_o, mon_e.out, mon_e.illegal);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_inst(input logic [31:0] inst, input logic [31:0] pc);
    int waited;
    waited = 0;
    in_valid_i = 1'b1;
    in_i = '{inst: inst, pc: pc, pc4: pc + 32'd4};
    while (!in_ready_o && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready_o) begin
      n_checks++;
      $display("FAIL push_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL %s_drain: got %0d pending expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  localparam logic [31:0] I_ADDI = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] I_LUI  = 32'h1234_52B7;  // lui  x5,0x12345
  localparam logic [31:0] I_SW   = 32'h0020_A423;  // sw   x2,8(x1)
  localparam logic [31:0] I_LW   = 32'hFFC0_A303;  // lw   x6,-4(x1)
  localparam logic [31:0] I_ADD1 = 32'h0021_8233;  // add  x4,x3,x2
  localparam logic [31:0] I_ADD2 = 32'h0020_03B3;  // add  x7,x0,x2
  localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

  function automatic id_stage_out_t exp_addi(input logic [31:0] pc);
    return mk(pc, 32'd5, 32'd0, 32'h1000_0005, 5'd1, 5'd0, 5'd5, 3'd0, 1'b0, 7'h13, 1'b1, 1'b0, 1'b0);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_i = '0;
    wb_en_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    ex_load_i = 1'b0; ex_rd_i = '0; out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid_o, 0);
    check("reset_in_ready", in_ready_o, 1);
    check("reset_illegal", illegal_o, 0);
    check("reset_stall_cnt", stall_cnt_o, 0);
    check("reset_id_out", id_out_o, 0);
    rst = 1'b0;
    tick();

    // Basic issue and one-cycle latency
    out_ready_i = 1'b1;
    expect_out(exp_addi(32'h100), 1'b0);
    push_inst(I_ADDI, 32'h100);
    check("no_fall_through", out_valid_o, 0);
    tick();
    check("addi_valid", out_valid_o, 1);
    wait_drain("addi");

    // Backpressure: out holds first, two more fill the queue
    out_ready_i = 1'b0;
    expect_out(exp_addi(32'h200), 1'b0);
    expect_out(mk(32'h204, 32'h1234_5000, 32'h1000_0008, 32'h1000_0003, 5'd5, 5'd8, 5'd3,
                  3'd5, 1'b0, 7'h37, 1'b1, 1'b0, 1'b0), 1'b0);
    expect_out(mk(32'h208, 32'd8, 32'h1000_0001, 32'h0000_0001, 5'd8, 5'd1, 5'd2,
                  3'd2, 1'b0, 7'h23, 1'b0, 1'b1, 1'b1), 1'b0);
    expect_out(mk(32'h20C, 32'hFFFF_FFFC, 32'h1000_0001, 32'h1000_001C, 5'd6, 5'd1, 5'd28,
                  3'd2, 1'b1, 7'h03, 1'b1, 1'b1, 1'b0), 1'b0);
    push_inst(I_ADDI, 32'h200);
    push_inst(I_LUI,  32'h204);
    push_inst(I_SW,   32'h208);
    in_valid_i = 1'b1;
    in_i = '{inst: I_LW, pc: 32'h20C, pc4: 32'h210};
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", in_ready_o, 0);
      check("bp_out_valid", out_valid_o, 1);
      check("bp_hold", id_out_o, exp_addi(32'h200));
      tick();
    end
    out_ready_i = 1'b1;
    push_inst(I_LW, 32'h20C);
    wait_drain("backpressure");

    // Load-use interlock: one bubble, then issue
    ex_load_i = 1'b1; ex_rd_i = 5'd3;
    expect_out(mk(32'h300, 32'd0, 32'h1000_0003, 32'h0000_0001, 5'd4, 5'd3, 5'd2,
                  3'd0, 1'b0, 7'h33, 1'b1, 1'b0, 1'b0), 1'b0);
    push_inst(I_ADD1, 32'h300);
    tick();
    check("lu_bubble", out_valid_o, 0);
    check("lu_stall_cnt", stall_cnt_o, 1);
    ex_load_i = 1'b0; ex_rd_i = 5'd0;
    tick();
    check("lu_issue", out_valid_o, 1);
    wait_drain("loaduse");
    check("lu_stall_cnt_after", stall_cnt_o, 1);

    // WB bypass and x0
    wb_en_i = 1'b1; wb_rd_i = 5'd2; wb_data_i = 32'h0000_DEAD;
    expect_out(mk(32'h400, 32'd0, 32'd0, 32'h0000_DEAD, 5'd7, 5'd0, 5'd2,
                  3'd0, 1'b0, 7'h33, 1'b1, 1'b0, 1'b0), 1'b0);
    push_inst(I_ADD2, 32'h400);
    wait_drain("bypass");
    wb_rd_i = 5'd0; wb_data_i = 32'h0000_0055;
    expect_out(mk(32'h404, 32'd0, 32'd0, 32'h0000_0001, 5'd7, 5'd0, 5'd2,
                  3'd0, 1'b0, 7'h33, 1'b1, 1'b0, 1'b0), 1'b0);
    push_inst(I_ADD2, 32'h404);
    wait_drain("x0");
    wb_en_i = 1'b0;

    // Illegal opcode, with a load to x31 in EX: must not stall
    ex_load_i = 1'b1; ex_rd_i = 5'd31;
    expect_out(mk(32'h500, 32'd0, 32'h1000_001F, 32'h1000_001F, 5'd31, 5'd31, 5'd31,
                  3'd7, 1'b1, 7'h7F, 1'b0, 1'b0, 1'b0), 1'b1);
    push_inst(I_BAD, 32'h500);
    wait_drain("illegal");
    check("illegal_no_stall", stall_cnt_o, 1);
    ex_load_i = 1'b0; ex_rd_i = 5'd0;

    // Flush with queue full and output valid; concurrent push dropped
    out_ready_i = 1'b0;
    push_inst(I_ADDI, 32'h600);
    push_inst(I_LUI,  32'h604);
    push_inst(I_SW,   32'h608);
    check("pre_flush_in_ready", in_ready_o, 0);
    check("pre_flush_out_valid", out_valid_o, 1);
    flush_i = 1'b1; in_valid_i = 1'b1;
    in_i = '{inst: I_LW, pc: 32'h60C, pc4: 32'h610};
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("flush_out_valid", out_valid_o, 0);
    check("flush_in_ready", in_ready_o, 1);
    check("flush_keeps_stall", stall_cnt_o, 1);
    out_ready_i = 1'b1;
    repeat (3) tick();
    check("flush_nothing_left", out_valid_o, 0);

    // Asynchronous reset mid-stream
    out_ready_i = 1'b0;
    push_inst(I_ADDI, 32'h700);
    push_inst(I_LUI,  32'h704);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid_o, 0);
    check("arst_id_out", id_out_o, 0);
    check("arst_illegal", illegal_o, 0);
    check("arst_stall_cnt", stall_cnt_o, 0);
    check("arst_in_ready", in_ready_o, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) tick();
    check("arst_queue_empty", out_valid_o, 0);

    expect_out(exp_addi(32'h800), 1'b0);
    push_inst(I_ADDI, 32'h800);
    wait_drain("post_reset");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
